// File: rtl/alu_rs.sv
// Integer ALU reservation station: holds renamed instructions until both operands resolve, snoops both CDBs, issues lowest ready entry.
// Optional build macro ALU_RS_PERF_EN adds issue and full-cycle performance counters.
module alu_rs #(
    parameter int RS_SIZE = 16,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic              dispatch_enable,
    input  logic [OP_W-1:0]   dispatch_op,
    input  logic [31:0]       dispatch_imm,
    input  logic [31:0]       dispatch_pc,
    input  logic              dispatch_reg1_valid,
    input  logic [31:0]       dispatch_reg1_data,
    input  logic [TAG_W-1:0]  dispatch_reg1_tag,
    input  logic              dispatch_reg2_valid,
    input  logic [31:0]       dispatch_reg2_data,
    input  logic [TAG_W-1:0]  dispatch_reg2_tag,
    input  logic [TAG_W-1:0]  dispatch_reg_dest_tag,
    input  logic              ALU_cdb_valid,
    input  logic [TAG_W-1:0]  ALU_cdb_tag,
    input  logic [31:0]       ALU_cdb_data,
    input  logic              LSB_cdb_valid,
    input  logic [TAG_W-1:0]  LSB_cdb_tag,
    input  logic [31:0]       LSB_cdb_data,
    output logic              full,
    output logic              ALU_enable,
    output logic [OP_W-1:0]   ALU_op,
    output logic [31:0]       ALU_reg1,
    output logic [31:0]       ALU_reg2,
    output logic [31:0]       ALU_imm,
    output logic [31:0]       ALU_pc,
    output logic [TAG_W-1:0]  ALU_reg_dest_tag
`ifdef ALU_RS_PERF_EN
    ,
    output logic [31:0]       perf_issue_count,
    output logic [31:0]       perf_full_cycles
`endif
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int CNT_W = $clog2(RS_SIZE + 1);
    localparam logic [CNT_W-1:0] FULL_THR = CNT_W'(RS_SIZE - 1);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] r1_q, r1_d, r2_q, r2_d;
    logic [31:0]        v1_q   [RS_SIZE];
    logic [31:0]        v1_d   [RS_SIZE];
    logic [31:0]        v2_q   [RS_SIZE];
    logic [31:0]        v2_d   [RS_SIZE];
    logic [TAG_W-1:0]   q1_q   [RS_SIZE];
    logic [TAG_W-1:0]   q1_d   [RS_SIZE];
    logic [TAG_W-1:0]   q2_q   [RS_SIZE];
    logic [TAG_W-1:0]   q2_d   [RS_SIZE];
    logic [TAG_W-1:0]   dest_q [RS_SIZE];
    logic [TAG_W-1:0]   dest_d [RS_SIZE];
    logic [OP_W-1:0]    op_q   [RS_SIZE];
    logic [OP_W-1:0]    op_d   [RS_SIZE];
    logic [31:0]        imm_q  [RS_SIZE];
    logic [31:0]        imm_d  [RS_SIZE];
    logic [31:0]        pc_q   [RS_SIZE];
    logic [31:0]        pc_d   [RS_SIZE];

    logic [32:0]        wk1    [RS_SIZE];
    logic [32:0]        wk2    [RS_SIZE];
    logic [32:0]        byp1, byp2;

    logic               issue_vld, alloc_vld, issue_fire;
    logic [IDX_W-1:0]   issue_idx, alloc_idx;
    logic [CNT_W-1:0]   occ;

    logic               full_q;
    logic               alu_en_q;
    logic [OP_W-1:0]    alu_op_q;
    logic [31:0]        alu_reg1_q, alu_reg2_q, alu_imm_q, alu_pc_q;
    logic [TAG_W-1:0]   alu_dest_q;

    // Returns {hit, data}; the ALU bus takes precedence over the load bus.
    function automatic logic [32:0] snoop(
        input logic [TAG_W-1:0] tag,
        input logic             a_v,
        input logic [TAG_W-1:0] a_t,
        input logic [31:0]      a_d,
        input logic             l_v,
        input logic [TAG_W-1:0] l_t,
        input logic [31:0]      l_d
    );
        if (a_v && (a_t == tag))
            return {1'b1, a_d};
        else if (l_v && (l_t == tag))
            return {1'b1, l_d};
        else
            return {1'b0, 32'h0};
    endfunction

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            wk1[i] = snoop(q1_q[i], ALU_cdb_valid, ALU_cdb_tag, ALU_cdb_data,
                           LSB_cdb_valid, LSB_cdb_tag, LSB_cdb_data);
            wk2[i] = snoop(q2_q[i], ALU_cdb_valid, ALU_cdb_tag, ALU_cdb_data,
                           LSB_cdb_valid, LSB_cdb_tag, LSB_cdb_data);
        end
        byp1 = snoop(dispatch_reg1_tag, ALU_cdb_valid, ALU_cdb_tag, ALU_cdb_data,
                     LSB_cdb_valid, LSB_cdb_tag, LSB_cdb_data);
        byp2 = snoop(dispatch_reg2_tag, ALU_cdb_valid, ALU_cdb_tag, ALU_cdb_data,
                     LSB_cdb_valid, LSB_cdb_tag, LSB_cdb_data);
    end

    // Both pickers scan downward so the lowest index ends up selected.
    always_comb begin
        issue_vld = 1'b0;
        issue_idx = '0;
        alloc_vld = 1'b0;
        alloc_idx = '0;
        occ       = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (busy_q[i] && r1_q[i] && r2_q[i]) begin
                issue_vld = 1'b1;
                issue_idx = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                alloc_vld = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < RS_SIZE; i++)
            occ = occ + CNT_W'(busy_q[i]);
    end

    assign issue_fire = rdy_in && !clear && issue_vld;

    always_comb begin
        busy_d = busy_q;
        r1_d   = r1_q;
        r2_d   = r2_q;
        v1_d   = v1_q;
        v2_d   = v2_q;
        q1_d   = q1_q;
        q2_d   = q2_q;
        dest_d = dest_q;
        op_d   = op_q;
        imm_d  = imm_q;
        pc_d   = pc_q;
        if (clear) begin
            busy_d = '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && !r1_q[i] && wk1[i][32]) begin
                    r1_d[i] = 1'b1;
                    v1_d[i] = wk1[i][31:0];
                end
                if (busy_q[i] && !r2_q[i] && wk2[i][32]) begin
                    r2_d[i] = 1'b1;
                    v2_d[i] = wk2[i][31:0];
                end
            end
            if (issue_vld)
                busy_d[issue_idx] = 1'b0;
            // Allocation only sees slots free in registered state, so it never collides with issue.
            if (dispatch_enable && alloc_vld) begin
                busy_d[alloc_idx] = 1'b1;
                op_d[alloc_idx]   = dispatch_op;
                imm_d[alloc_idx]  = dispatch_imm;
                pc_d[alloc_idx]   = dispatch_pc;
                dest_d[alloc_idx] = dispatch_reg_dest_tag;
                q1_d[alloc_idx]   = dispatch_reg1_tag;
                q2_d[alloc_idx]   = dispatch_reg2_tag;
                r1_d[alloc_idx]   = dispatch_reg1_valid | byp1[32];
                r2_d[alloc_idx]   = dispatch_reg2_valid | byp2[32];
                v1_d[alloc_idx]   = dispatch_reg1_valid ? dispatch_reg1_data : byp1[31:0];
                v2_d[alloc_idx]   = dispatch_reg2_valid ? dispatch_reg2_data : byp2[31:0];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        r1_q   <= r1_d;
        r2_q   <= r2_d;
        v1_q   <= v1_d;
        v2_q   <= v2_d;
        q1_q   <= q1_d;
        q2_q   <= q2_d;
        dest_q <= dest_d;
        op_q   <= op_d;
        imm_q  <= imm_d;
        pc_q   <= pc_d;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q     <= '0;
            full_q     <= 1'b0;
            alu_en_q   <= 1'b0;
            alu_op_q   <= '0;
            alu_reg1_q <= '0;
            alu_reg2_q <= '0;
            alu_imm_q  <= '0;
            alu_pc_q   <= '0;
            alu_dest_q <= '0;
        end else begin
            busy_q   <= busy_d;
            full_q   <= (occ >= FULL_THR);
            alu_en_q <= issue_fire;
            if (issue_fire) begin
                alu_op_q   <= op_q[issue_idx];
                alu_reg1_q <= v1_q[issue_idx];
                alu_reg2_q <= v2_q[issue_idx];
                alu_imm_q  <= imm_q[issue_idx];
                alu_pc_q   <= pc_q[issue_idx];
                alu_dest_q <= dest_q[issue_idx];
            end
        end
    end

    assign full             = full_q;
    assign ALU_enable       = alu_en_q;
    assign ALU_op           = alu_op_q;
    assign ALU_reg1         = alu_reg1_q;
    assign ALU_reg2         = alu_reg2_q;
    assign ALU_imm          = alu_imm_q;
    assign ALU_pc           = alu_pc_q;
    assign ALU_reg_dest_tag = alu_dest_q;

`ifdef ALU_RS_PERF_EN
    logic [31:0] perf_issue_q, perf_full_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            perf_issue_q <= '0;
            perf_full_q  <= '0;
        end else begin
            if (alu_en_q)
                perf_issue_q <= perf_issue_q + 32'd1;
            if (full_q && rdy_in)
                perf_full_q <= perf_full_q + 32'd1;
        end
    end

    assign perf_issue_count = perf_issue_q;
    assign perf_full_cycles = perf_full_q;
`endif

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: a behavioural entry-table model predicts issues and full, a negedge monitor compares.
module tb_alu_rs;
    localparam int RS = 16;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, dispatch_enable;
    logic [5:0]  dispatch_op;
    logic [31:0] dispatch_imm, dispatch_pc;
    logic        dispatch_reg1_valid, dispatch_reg2_valid;
    logic [31:0] dispatch_reg1_data, dispatch_reg2_data;
    logic [3:0]  dispatch_reg1_tag, dispatch_reg2_tag, dispatch_reg_dest_tag;
    logic        ALU_cdb_valid, LSB_cdb_valid;
    logic [3:0]  ALU_cdb_tag, LSB_cdb_tag;
    logic [31:0] ALU_cdb_data, LSB_cdb_data;
    logic        full, ALU_enable;
    logic [5:0]  ALU_op;
    logic [31:0] ALU_reg1, ALU_reg2, ALU_imm, ALU_pc;
    logic [3:0]  ALU_reg_dest_tag;
`ifdef ALU_RS_PERF_EN
    logic [31:0] perf_issue_count, perf_full_cycles;
`endif

    alu_rs #(.RS_SIZE(RS), .TAG_W(4), .OP_W(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .dispatch_enable(dispatch_enable), .dispatch_op(dispatch_op),
        .dispatch_imm(dispatch_imm), .dispatch_pc(dispatch_pc),
        .dispatch_reg1_valid(dispatch_reg1_valid), .dispatch_reg1_data(dispatch_reg1_data),
        .dispatch_reg1_tag(dispatch_reg1_tag),
        .dispatch_reg2_valid(dispatch_reg2_valid), .dispatch_reg2_data(dispatch_reg2_data),
        .dispatch_reg2_tag(dispatch_reg2_tag), .dispatch_reg_dest_tag(dispatch_reg_dest_tag),
        .ALU_cdb_valid(ALU_cdb_valid), .ALU_cdb_tag(ALU_cdb_tag), .ALU_cdb_data(ALU_cdb_data),
        .LSB_cdb_valid(LSB_cdb_valid), .LSB_cdb_tag(LSB_cdb_tag), .LSB_cdb_data(LSB_cdb_data),
        .full(full), .ALU_enable(ALU_enable), .ALU_op(ALU_op), .ALU_reg1(ALU_reg1),
        .ALU_reg2(ALU_reg2), .ALU_imm(ALU_imm), .ALU_pc(ALU_pc),
        .ALU_reg_dest_tag(ALU_reg_dest_tag)
`ifdef ALU_RS_PERF_EN
        , .perf_issue_count(perf_issue_count), .perf_full_cycles(perf_full_cycles)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          busy, r1, r2;
        logic [5:0]  op;
        logic [31:0] imm, pc, v1, v2;
        logic [3:0]  q1, q2, dest;
    } ent_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] r1, r2, imm, pc;
        logic [3:0]  dest;
    } iss_t;

    ent_t m [RS];
    iss_t exp_q [$];
    bit   exp_en = 0;
    bit   exp_full = 0;
    bit   chk_on = 0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cdb_lookup(input logic [3:0] tag, output bit hit, output logic [31:0] d);
        hit = 0;
        d   = 32'h0;
        if (ALU_cdb_valid && ALU_cdb_tag == tag) begin
            hit = 1; d = ALU_cdb_data;
        end else if (LSB_cdb_valid && LSB_cdb_tag == tag) begin
            hit = 1; d = LSB_cdb_data;
        end
    endtask

    // Predicts the effect of one rising edge from the inputs currently applied.
    task automatic model_step();
        int          sel, fr, cnt;
        bit          hit;
        logic [31:0] d;
        iss_t        rec;
        cnt = 0;
        foreach (m[i]) if (m[i].busy) cnt++;
        exp_full = (cnt >= RS - 1);
        exp_en   = 0;
        if (clear) begin
            foreach (m[i]) m[i].busy = 0;
        end else if (rdy_in) begin
            sel = -1;
            fr  = -1;
            foreach (m[i]) begin
                if (sel < 0 && m[i].busy && m[i].r1 && m[i].r2) sel = i;
                if (fr < 0 && !m[i].busy) fr = i;
            end
            if (sel >= 0) begin
                rec = '{op: m[sel].op, r1: m[sel].v1, r2: m[sel].v2, imm: m[sel].imm,
                        pc: m[sel].pc, dest: m[sel].dest};
                exp_q.push_back(rec);
                exp_en = 1;
            end
            foreach (m[i]) begin
                if (m[i].busy && !m[i].r1) begin
                    cdb_lookup(m[i].q1, hit, d);
                    if (hit) begin m[i].r1 = 1; m[i].v1 = d; end
                end
                if (m[i].busy && !m[i].r2) begin
                    cdb_lookup(m[i].q2, hit, d);
                    if (hit) begin m[i].r2 = 1; m[i].v2 = d; end
                end
            end
            if (sel >= 0) m[sel].busy = 0;
            if (dispatch_enable && fr >= 0) begin
                m[fr].busy = 1;
                m[fr].op   = dispatch_op;
                m[fr].imm  = dispatch_imm;
                m[fr].pc   = dispatch_pc;
                m[fr].dest = dispatch_reg_dest_tag;
                m[fr].q1   = dispatch_reg1_tag;
                m[fr].q2   = dispatch_reg2_tag;
                cdb_lookup(dispatch_reg1_tag, hit, d);
                m[fr].r1 = dispatch_reg1_valid || hit;
                m[fr].v1 = dispatch_reg1_valid ? dispatch_reg1_data : d;
                cdb_lookup(dispatch_reg2_tag, hit, d);
                m[fr].r2 = dispatch_reg2_valid || hit;
                m[fr].v2 = dispatch_reg2_valid ? dispatch_reg2_data : d;
            end
        end
    endtask

    always @(negedge clk_in) begin
        iss_t e, a;
        if (chk_on) begin
            check("alu_enable", {63'd0, ALU_enable}, {63'd0, exp_en});
            check("full", {63'd0, full}, {63'd0, exp_full});
            if (exp_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (ALU_enable) begin
                    a = '{op: ALU_op, r1: ALU_reg1, r2: ALU_reg2, imm: ALU_imm,
                          pc: ALU_pc, dest: ALU_reg_dest_tag};
                    vectors++;
                    if (a !== e) begin
                        miscompares++;
                        $display("FAIL issue: got op=%h r1=%h r2=%h imm=%h pc=%h dest=%h expected op=%h r1=%h r2=%h imm=%h pc=%h dest=%h",
                                 a.op, a.r1, a.r2, a.imm, a.pc, a.dest, e.op, e.r1, e.r2, e.imm, e.pc, e.dest);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    task automatic idle();
        rdy_in = 1; clear = 0; dispatch_enable = 0;
        ALU_cdb_valid = 0; LSB_cdb_valid = 0;
    endtask

    task automatic disp(input logic [5:0] op, input bit v1, input logic [31:0] d1, input logic [3:0] t1,
                        input bit v2, input logic [31:0] d2, input logic [3:0] t2, input logic [3:0] dst);
        dispatch_enable = 1; dispatch_op = op;
        dispatch_imm = $urandom; dispatch_pc = $urandom;
        dispatch_reg1_valid = v1; dispatch_reg1_data = d1; dispatch_reg1_tag = t1;
        dispatch_reg2_valid = v2; dispatch_reg2_data = d2; dispatch_reg2_tag = t2;
        dispatch_reg_dest_tag = dst;
    endtask

    task automatic rand_cycle(input int cdb_pct);
        idle();
        rdy_in = ($urandom_range(0, 9) != 0);
        clear  = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 1) == 1)
            disp(6'($urandom), 1'($urandom), $urandom, 4'($urandom),
                 1'($urandom), $urandom, 4'($urandom), 4'($urandom));
        ALU_cdb_valid = ($urandom_range(0, 99) < cdb_pct);
        LSB_cdb_valid = ($urandom_range(0, 99) < cdb_pct);
        ALU_cdb_tag = 4'($urandom); ALU_cdb_data = $urandom;
        LSB_cdb_tag = 4'($urandom); LSB_cdb_data = $urandom;
        if (LSB_cdb_tag == ALU_cdb_tag) LSB_cdb_tag = LSB_cdb_tag ^ 4'h1;
        tick();
    endtask

    initial begin
        foreach (m[i]) m[i].busy = 0;
        rst_in = 0;
        idle();
        disp(6'd0, 0, 32'd0, 4'd0, 0, 32'd0, 4'd0, 4'd0);
        dispatch_enable = 0;
        ALU_cdb_tag = 0; ALU_cdb_data = 0; LSB_cdb_tag = 0; LSB_cdb_data = 0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_full", {63'd0, full}, 64'd0);
        check("rst_alu_enable", {63'd0, ALU_enable}, 64'd0);
        check("rst_alu_op", {58'd0, ALU_op}, 64'd0);
        check("rst_alu_reg1", {32'd0, ALU_reg1}, 64'd0);
        check("rst_alu_reg2", {32'd0, ALU_reg2}, 64'd0);
        check("rst_alu_imm_pc", {ALU_imm, ALU_pc}, 64'd0);
        check("rst_alu_dest", {60'd0, ALU_reg_dest_tag}, 64'd0);
        rst_in = 1;
        chk_on = 1;

        // Ready operands: issue two edges after dispatch.
        idle(); disp(6'd1, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0, 4'd3); tick();
        idle(); repeat (3) tick();

        // Pending operand woken by the load bus.
        disp(6'd2, 0, 32'd0, 4'd9, 1, 32'd1, 4'd0, 4'd6); tick();
        idle(); repeat (2) tick();
        LSB_cdb_valid = 1; LSB_cdb_tag = 4'd9; LSB_cdb_data = 32'h1234; tick();
        idle(); repeat (3) tick();

        // Same-cycle bypass at dispatch from the ALU bus.
        disp(6'd3, 1, 32'd2, 4'd0, 0, 32'd0, 4'd4, 4'd7);
        ALU_cdb_valid = 1; ALU_cdb_tag = 4'd4; ALU_cdb_data = 32'hAA; tick();
        idle(); repeat (3) tick();

        // Fill RS-1 entries, then release one.
        for (int i = 0; i < RS - 1; i++) begin
            disp(6'(i), 0, 32'd0, 4'(i), 1, 32'(i), 4'd0, 4'(i)); tick();
        end
        idle(); tick();
        check("full_after_fill", {63'd0, full}, 64'd1);
        ALU_cdb_valid = 1; ALU_cdb_tag = 4'd5; ALU_cdb_data = 32'h55; tick();
        idle(); tick();
        check("full_during_issue", {63'd0, full}, 64'd1);
        tick();
        check("full_after_issue", {63'd0, full}, 64'd0);
        for (int i = 0; i < RS - 1; i++) begin
            ALU_cdb_valid = 1; ALU_cdb_tag = 4'(i); ALU_cdb_data = 32'h100 + 32'(i); tick();
        end
        idle(); repeat (4) tick();

        // Clear with concurrent dispatch and matching broadcast.
        for (int i = 0; i < 8; i++) begin
            disp(6'(i), 0, 32'd0, 4'(i), 0, 32'd0, 4'(i), 4'(i)); tick();
        end
        idle(); clear = 1;
        disp(6'd9, 1, 32'd1, 4'd0, 1, 32'd2, 4'd0, 4'd1);
        ALU_cdb_valid = 1; ALU_cdb_tag = 4'd2; ALU_cdb_data = 32'h22; tick();
        idle(); repeat (4) tick();
        check("full_after_clear", {63'd0, full}, 64'd0);
        disp(6'd10, 1, 32'd3, 4'd0, 1, 32'd4, 4'd0, 4'd2); tick();
        idle(); repeat (3) tick();

        // Freeze with a ready entry.
        disp(6'd11, 1, 32'd8, 4'd0, 1, 32'd9, 4'd0, 4'd5); tick();
        idle(); rdy_in = 0; repeat (3) tick();
        idle(); repeat (3) tick();

        for (int c = 0; c < 1500; c++) rand_cycle(40);
        for (int c = 0; c < 1500; c++) rand_cycle(8);
        idle();
        repeat (40) begin
            ALU_cdb_valid = 1; ALU_cdb_tag = 4'($urandom); ALU_cdb_data = $urandom; tick();
        end
        idle(); clear = 1; tick();
        idle(); repeat (3) tick();
        chk_on = 0;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
